// File: rtl/serial_word_tx.sv
// -----------------------------------------------------------------------------
// serial_word_tx
//   Parallel-to-serial transmitter, source end of the bit-serial link into the
//   two's-complement stage. A WIDTH-bit word is taken over a valid/ready
//   handshake and shifted out LSB first, one bit per clock. The restart strobe
//   r marks bit 0 of every word so the sink can re-arm its carry.
//
//   Build option:
//     SER_TX_PARITY_EN  - when defined, each word is followed by one extra
//                         cycle carrying its even parity bit (frame = WIDTH+1).
//                         When undefined the frame is exactly WIDTH cycles.
//
//   Parameters:
//     WIDTH      bits per word, 2..32
//
//   Ports:
//     t_clk      in   clock, rising edge
//     r_n        in   asynchronous active-low reset
//     din        in   parallel word, captured on accept
//     din_valid  in   source has a word on din
//     din_ready  out  transmitter can take a word (transfer = valid & ready)
//     i          out  serial data, LSB first
//     r          out  word-start strobe, high during bit 0 only
//     last       out  high during the final serial cycle of a frame
//     busy       out  high while a word (or its parity bit) is on i
//
//   Every output is decoded from state registers only; din/din_valid never
//   reach an output combinationally.
// -----------------------------------------------------------------------------
module serial_word_tx #(
    parameter int WIDTH = 12
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             i,
    output logic             r,
    output logic             last,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             at_last;
    logic             accept;

`ifdef SER_TX_PARITY_EN
    // shreg is consumed while shifting, so the parity source is a separate
    // untouched copy of the accepted word.
    logic [WIDTH-1:0] hold, hold_nx;
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
`ifdef SER_TX_PARITY_EN
            hold  <= '0;
`endif
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
`ifdef SER_TX_PARITY_EN
            hold  <= hold_nx;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Output decode and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        din_ready = 1'b0;
        i         = 1'b0;
        r         = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        state_nx  = state;
        shreg_nx  = shreg;
        cnt_nx    = cnt;
`ifdef SER_TX_PARITY_EN
        hold_nx   = hold;
`endif
        at_last   = (cnt == CNT_LAST);

        // Outputs depend on registered state only.
        case (state)
            IDLE: begin
                din_ready = 1'b1;
            end
            SHIFT: begin
                i    = shreg[0];
                busy = 1'b1;
                r    = (cnt == '0);
`ifdef SER_TX_PARITY_EN
                // The parity cycle follows, so the data bit is not the end
                // of the frame and no new word can be taken yet.
                last      = 1'b0;
                din_ready = 1'b0;
`else
                // Ready on the final bit lets the next word start with no gap.
                last      = at_last;
                din_ready = at_last;
`endif
            end
`ifdef SER_TX_PARITY_EN
            PAR: begin
                i         = ^hold;
                last      = 1'b1;
                busy      = 1'b1;
                din_ready = 1'b1;
            end
`endif
            default: begin
            end
        endcase

        accept = din_valid & din_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SHIFT;
                    shreg_nx = din;
                    cnt_nx   = '0;
                end
            end
            SHIFT: begin
                shreg_nx = shreg >> 1;
                cnt_nx   = cnt + CW'(1);
                if (at_last) begin
                    // cnt wraps here so it never passes WIDTH-1.
                    cnt_nx = '0;
`ifdef SER_TX_PARITY_EN
                    state_nx = PAR;
`else
                    if (accept) begin
                        shreg_nx = din;
                    end else begin
                        state_nx = IDLE;
                    end
`endif
                end
            end
`ifdef SER_TX_PARITY_EN
            PAR: begin
                if (accept) begin
                    state_nx = SHIFT;
                    shreg_nx = din;
                    cnt_nx   = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase

`ifdef SER_TX_PARITY_EN
        if (accept) begin
            hold_nx = din;
        end
`endif
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_word_tx
//   Scoreboard bench for serial_word_tx (WIDTH=12). Every accepted word pushes
//   its expected serial frame (bit, start strobe, last flag) into a queue; the
//   monitor pops one entry per busy cycle and compares. Idle cycles must show
//   quiet outputs, din_ready high and an empty scoreboard (no gaps).
// -----------------------------------------------------------------------------
module tb_serial_word_tx;

    localparam int W = 12;
`ifdef SER_TX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         t_clk = 1'b0;
    logic         r_n   = 1'b0;
    logic [W-1:0] din   = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         i;
    logic         r;
    logic         last;
    logic         busy;

    typedef struct packed {
        logic i;
        logic r;
        logic last;
    } exp_t;

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   busy_cyc = 0;

    serial_word_tx #(.WIDTH(W)) dut (
        .t_clk     (t_clk),
        .r_n       (r_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .i         (i),
        .r         (r),
        .last      (last),
        .busy      (busy)
    );

    always #5 t_clk = ~t_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected frame for one word: LSB first, r on bit 0, last on the final cycle.
    task automatic push(input logic [W-1:0] w);
        exp_t e;
        for (int k = 0; k < W; k++) begin
            e.i    = w[k];
            e.r    = (k == 0);
`ifdef SER_TX_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (k == W - 1);
`endif
            sb.push_back(e);
        end
`ifdef SER_TX_PARITY_EN
        e.i    = ^w;
        e.r    = 1'b0;
        e.last = 1'b1;
        sb.push_back(e);
`endif
    endtask

    // Monitor on the falling edge: inputs were driven just after the rising
    // edge and outputs are settled.
    always @(negedge t_clk) begin
        exp_t e;
        if (r_n) begin
            if (busy) begin
                busy_cyc++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("i", i, e.i);
                    chk("r", r, e.r);
                    chk("last", last, e.last);
                    // Ready coincides with the final cycle of a frame.
                    chk("ready", din_ready, e.last);
                end
            end else begin
                chk("idle_out", {i, r, last}, 0);
                chk("idle_ready", din_ready, 1);
                chk("idle_sb", sb.size(), 0);
            end
            if (din_valid && din_ready) push(din);
        end
    end

    // Present a word and hold it until the DUT takes it; leaves din_valid high.
    task automatic send(input logic [W-1:0] w);
        bit done = 1'b0;
        din       = w;
        din_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            done = din_ready;
            @(posedge t_clk);
            #1;
        end
        chk("send_timeout", done, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && busy; n++) begin
            @(posedge t_clk);
            #1;
        end
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] obs;
        logic [W-1:0] v;
        int           b0;
        bit           done;

        // Reset asserted from time zero, checked before any clock edge.
        #1;
        chk("rst_i", i, 0);
        chk("rst_r", r, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", din_ready, 1);
        @(posedge t_clk);
        #1;
        r_n = 1'b1;
        @(posedge t_clk);
        #1;

        // Single word: bit 0 appears the cycle after the accept edge.
        send(12'h7A5);
        din_valid = 1'b0;
        obs = '0;
        for (int k = 0; k < W; k++) begin
            obs[k] = i;
            if (k == 0) chk("t2_r_first", r, 1);
            @(posedge t_clk);
            #1;
        end
        chk("t2_word", obs, 12'h7A5);
`ifdef SER_TX_PARITY_EN
        chk("t2_par_i", i, 1);
        chk("t2_par_last", last, 1);
        chk("t2_par_ready", din_ready, 1);
        @(posedge t_clk);
        #1;
`endif
        chk("t2_idle", busy, 0);

        // Back-to-back with din_valid held: no gap between frames.
        b0 = busy_cyc;
        send(12'h001);
        send(12'hFFF);
        din_valid = 1'b0;
        drain();
        chk("t3_busy_run", busy_cyc - b0, 2 * FRAME);

        // Reset mid-word, asynchronously between edges.
        send(12'hFFF);
        din_valid = 1'b0;
        repeat (4) @(posedge t_clk);
        #3;
        r_n = 1'b0;
        sb.delete();
        #1;
        chk("t4_i", i, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ready", din_ready, 1);
        chk("t4_last", last, 0);
        @(posedge t_clk);
        #1;
        r_n = 1'b1;
        send(12'h003);
        din_valid = 1'b0;
        chk("t4_r_restart", r, 1);
        chk("t4_bit0", i, 1);
        drain();

        // Backpressure: din toggles while not ready; only the value on the
        // ready edge may be sent (scoreboard captures it at that edge).
        send(12'h555);
        v = 12'h111;
        din = v;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            done = din_ready;
            @(posedge t_clk);
            #1;
            if (!done) begin
                v   = (v == 12'h111) ? 12'h222 : 12'h111;
                din = v;
            end
        end
        chk("t5_accept", done, 1);
        din_valid = 1'b0;
        din = 12'h000;
        drain();

        // Random words with random gaps.
        for (int n = 0; n < 6; n++) begin
            send(W'($urandom));
            if ($urandom_range(0, 1) == 1) din_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge t_clk);
            #1;
        end
        din_valid = 1'b0;
        drain();
        @(posedge t_clk);
        #1;
        chk("end_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
